spi_burst_memory: RTL

Parametrised SPI-slave memory: decodes a command frame (address + R/W bit), then serves one or more data frames from an internal array, auto-incrementing the address across a burst. It sits behind the three input conditioners (MOSI, SCLK, CS) in the FPGA top level and consumes their one-cycle edge pulses. It replaces the fixed 8-bit, single-byte SPI memory path.

---
 rtl/spi_mem_pkg.sv | 23 ++
 rtl/spi_mem_array.sv | 30 +++
 rtl/spi_burst_memory.sv | 172 +++++++++++++++++
 3 files changed

// File: rtl/spi_mem_pkg.sv
// rtl/spi_mem_pkg.sv - shared state enum, R/W encoding and counter sizing for the SPI memory
package spi_mem_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CMD,
    ST_RD_FETCH,
    ST_RD_SHIFT,
    ST_WR_SHIFT,
    ST_WR_COMMIT,
    ST_HOLD
  } spi_state_e;

  localparam logic RW_RD = 1'b1;

  // Bit counter must reach the longer of the command and data frames
  function automatic int cnt_width(input int addr_w, input int data_w);
    int m;
    m = (addr_w + 1 > data_w) ? addr_w + 1 : data_w;
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/spi_mem_array.sv
// rtl/spi_mem_array.sv - DEPTH x DATA_W storage, synchronous write, registered read
module spi_mem_array #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 7,
  parameter int DEPTH  = 2**ADDR_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  // Array write; out-of-range addresses are dropped
  always_ff @(posedge clk) begin
    if (we && (int'(waddr) < DEPTH)) mem[waddr] <= wdata;
  end

  // Registered read; out-of-range addresses read as zero
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                      rdata <= '0;
    else if (int'(raddr) < DEPTH)    rdata <= mem[raddr];
    else                             rdata <= '0;
  end

endmodule

// File: rtl/spi_burst_memory.sv
// rtl/spi_burst_memory.sv - SPI mode-0 slave memory; SPI_MEM_BURST_EN enables multi-frame bursts
module spi_burst_memory
  import spi_mem_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 7,
  parameter int DEPTH  = 2**ADDR_W
) (
  input  logic clk,
  input  logic rst_n,
  input  logic sclk_rise,
  input  logic sclk_fall,
  input  logic cs_n,
  input  logic mosi,
  output logic miso,
  output logic miso_oe,
  output logic busy,
  output logic frame_err
);

  localparam int CW = cnt_width(ADDR_W, DATA_W);
  localparam int SW = (ADDR_W + 1 > DATA_W) ? ADDR_W + 1 : DATA_W;

  spi_state_e        state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [SW-1:0]     sh_in_q, sh_in_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] sh_out_q, sh_out_d;
  logic              miso_q, miso_d;
  logic              ferr_q, ferr_d;
  logic              fph_q, fph_d;
  logic              we;
  logic [DATA_W-1:0] rdata;

`ifdef SPI_MEM_BURST_EN
  // Wrap at DEPTH, which may be smaller than the address space
  function automatic logic [ADDR_W-1:0] addr_inc(input logic [ADDR_W-1:0] a);
    return (int'(a) == DEPTH - 1) ? '0 : a + 1'b1;
  endfunction
`endif

  spi_mem_array #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH)) u_array (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (we),
    .waddr (addr_q),
    .wdata (sh_in_q[DATA_W-1:0]),
    .raddr (addr_q),
    .rdata (rdata)
  );

  assign miso      = miso_q;
  assign miso_oe   = (state_q == ST_RD_FETCH) || (state_q == ST_RD_SHIFT);
  assign busy      = (state_q != ST_IDLE);
  assign frame_err = ferr_q;

  // State and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      sh_in_q  <= '0;
      addr_q   <= '0;
      sh_out_q <= '0;
      miso_q   <= 1'b0;
      ferr_q   <= 1'b0;
      fph_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      sh_in_q  <= sh_in_d;
      addr_q   <= addr_d;
      sh_out_q <= sh_out_d;
      miso_q   <= miso_d;
      ferr_q   <= ferr_d;
      fph_q    <= fph_d;
    end
  end

  // Next-state and datapath decode; cs_n high overrides everything, including a same-cycle sclk_rise
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    sh_in_d  = sh_in_q;
    addr_d   = addr_q;
    sh_out_d = sh_out_q;
    miso_d   = miso_q;
    ferr_d   = ferr_q;
    fph_d    = 1'b0;
    // A fully shifted word commits even if cs_n rises during the commit cycle
    we       = (state_q == ST_WR_COMMIT);
    if (cs_n) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
      miso_d  = 1'b0;
      if (cnt_q != '0) ferr_d = 1'b1;
    end else begin
      case (state_q)
        ST_IDLE: begin
          state_d = ST_CMD;
          cnt_d   = '0;
          ferr_d  = 1'b0;
        end
        ST_CMD: begin
          if (sclk_rise) begin
            sh_in_d = {sh_in_q[SW-2:0], mosi};
            if (cnt_q == CW'(ADDR_W)) begin
              addr_d  = sh_in_q[ADDR_W-1:0];
              cnt_d   = '0;
              state_d = (mosi == RW_RD) ? ST_RD_FETCH : ST_WR_SHIFT;
            end else begin
              cnt_d = cnt_q + 1'b1;
            end
          end
        end
        ST_RD_FETCH: begin
          // First cycle lets the registered array read settle, second loads it
          if (!fph_q) begin
            fph_d = 1'b1;
          end else begin
            sh_out_d = rdata;
            state_d  = ST_RD_SHIFT;
          end
        end
        ST_RD_SHIFT: begin
          // Word is done only once the master has sampled the last bit
          if (cnt_q == CW'(DATA_W)) begin
            if (sclk_rise) begin
              cnt_d = '0;
`ifdef SPI_MEM_BURST_EN
              addr_d  = addr_inc(addr_q);
              state_d = ST_RD_FETCH;
`else
              state_d = ST_HOLD;
`endif
            end
          end else if (sclk_fall) begin
            miso_d   = sh_out_q[DATA_W-1];
            sh_out_d = {sh_out_q[DATA_W-2:0], 1'b0};
            cnt_d    = cnt_q + 1'b1;
          end
        end
        ST_WR_SHIFT: begin
          if (sclk_rise) begin
            sh_in_d = {sh_in_q[SW-2:0], mosi};
            if (cnt_q == CW'(DATA_W - 1)) begin
              cnt_d   = '0;
              state_d = ST_WR_COMMIT;
            end else begin
              cnt_d = cnt_q + 1'b1;
            end
          end
        end
        ST_WR_COMMIT: begin
`ifdef SPI_MEM_BURST_EN
          addr_d  = addr_inc(addr_q);
          state_d = ST_WR_SHIFT;
`else
          state_d = ST_HOLD;
`endif
        end
        ST_HOLD: begin
          state_d = ST_HOLD;
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

endmodule
